bip_datapath: RTL

Execution datapath of the BIP single-cycle processor, directly downstream of `control`. It consumes the decoder strobes `selA`, `selB`, `wrAcc`, `op`, `wrRam` and `rdRam`, together with the 11-bit operand field of the current instruction. It holds the accumulator, the add/sub ALU, the operand sign-extender and the data memory. It executes one instruction per clock and flags signed overflow.

---
 rtl/bip_datapath_if.sv | 28 ++
 rtl/bip_datapath.sv | 87 ++++++++
 2 files changed

// File: rtl/bip_datapath_if.sv
// rtl/bip_datapath_if.sv - decoder strobe / datapath result bundle for the BIP datapath
interface bip_datapath_if #(
    parameter int NB_DATA          = 16,
    parameter int NB_OPERAND       = 11,
    parameter int NB_DECODER_SEL_A = 2,
    parameter int NB_DECODER       = 1
);
    logic [NB_OPERAND-1:0]       i_operand;
    logic [NB_DECODER_SEL_A-1:0] i_selA;
    logic [NB_DECODER-1:0]       i_selB;
    logic [NB_DECODER-1:0]       i_wrAcc;
    logic [NB_DECODER-1:0]       i_op;
    logic [NB_DECODER-1:0]       i_wrRam;
    logic [NB_DECODER-1:0]       i_rdRam;
    logic [NB_DATA-1:0]          o_acc;
    logic [NB_DATA-1:0]          o_mem_data;
    logic                        o_overflow;

    modport master (
        output i_operand, i_selA, i_selB, i_wrAcc, i_op, i_wrRam, i_rdRam,
        input  o_acc, o_mem_data, o_overflow
    );

    modport slave (
        input  i_operand, i_selA, i_selB, i_wrAcc, i_op, i_wrRam, i_rdRam,
        output o_acc, o_mem_data, o_overflow
    );
endinterface

// File: rtl/bip_datapath.sv
// rtl/bip_datapath.sv - BIP execution datapath: accumulator, add/sub ALU, sign-extender, data memory
module bip_datapath #(
    parameter int NB_DATA          = 16,
    parameter int NB_OPERAND       = 11,
    parameter int NB_ADDR          = 11,
    parameter int NB_DECODER_SEL_A = 2,
    parameter int NB_DECODER       = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    bip_datapath_if.slave  bus
);
    localparam int DEPTH = 1 << NB_ADDR;
    localparam logic [NB_DECODER-1:0]       STROBE_ON = NB_DECODER'(1);
    localparam logic [NB_DECODER_SEL_A-1:0] SEL_MEM   = NB_DECODER_SEL_A'(0);
    localparam logic [NB_DECODER_SEL_A-1:0] SEL_IMM   = NB_DECODER_SEL_A'(1);
    localparam logic [NB_DECODER_SEL_A-1:0] SEL_ALU   = NB_DECODER_SEL_A'(2);

    logic [NB_DATA-1:0] mem_q [DEPTH];
    logic [NB_DATA-1:0] acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic [NB_ADDR-1:0] addr;
    logic [NB_DATA-1:0] imm_ext;
    logic [NB_DATA-1:0] mem_rd;
    logic [NB_DATA-1:0] opb;
    logic [NB_DATA-1:0] alu;
    logic [NB_DATA-1:0] acc_src;
    logic               alu_ovf;
    logic               wr_acc;
    logic               wr_ram;

    always_comb begin
        addr    = bus.i_operand[NB_ADDR-1:0];
        imm_ext = {{(NB_DATA-NB_OPERAND){bus.i_operand[NB_OPERAND-1]}}, bus.i_operand};
        mem_rd  = (bus.i_rdRam == STROBE_ON) ? mem_q[addr] : '0;
        opb     = (bus.i_selB == STROBE_ON) ? imm_ext : mem_rd;
        wr_acc  = (bus.i_wrAcc == STROBE_ON);
        wr_ram  = (bus.i_wrRam == STROBE_ON);

        // Subtraction overflows when signs differ; addition when they match.
        if (bus.i_op == STROBE_ON) begin
            alu     = acc_q - opb;
            alu_ovf = (acc_q[NB_DATA-1] != opb[NB_DATA-1]) && (alu[NB_DATA-1] != acc_q[NB_DATA-1]);
        end else begin
            alu     = acc_q + opb;
            alu_ovf = (acc_q[NB_DATA-1] == opb[NB_DATA-1]) && (alu[NB_DATA-1] != acc_q[NB_DATA-1]);
        end

        case (bus.i_selA)
            SEL_MEM: acc_src = mem_rd;
            SEL_IMM: acc_src = imm_ext;
            SEL_ALU: acc_src = alu;
            default: acc_src = acc_q;
        endcase

        acc_d = acc_q;
        ovf_d = ovf_q;
        if (wr_acc) begin
            acc_d = acc_src;
            if ((bus.i_selA == SEL_ALU) && alu_ovf) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // Memory is not cleared by reset; only the write is suppressed.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_ram) begin
            mem_q[addr] <= acc_q;
        end
    end

    assign bus.o_acc      = acc_q;
    assign bus.o_mem_data = mem_rd;
    assign bus.o_overflow = ovf_q;
endmodule
